mmio_result_port: RTL and testbench
===================================

Name: mmio_result_port

Overview:
- Memory-mapped responder on the CPU data-memory bus (mem_write, data_memory_addr, write_data). It sits beside dmem in Top.
- Decodes CPU stores to the scratch and result words and decides pass/fail/timeout in hardware, so benches and FPGA builds need no bus-sniffing logic.
- Provides a combinational read-back path for status, scratch, result and cycle-count words, sized for the single-cycle CPU's load timing.

Parameters:
- SCRATCH_ADDR, 32'd96, scratch word; stores here are legal and latched.
- RESULT_ADDR, 32'd100, result word; any store here ends the run.
- STATUS_ADDR, 32'd104, read-only status word.
- CYCLE_ADDR, 32'd108, read-only cycle counter.
- EXPECTED, 32'd7, result value meaning success.
- TIMEOUT_CYCLES, 4096, cycles in RUN before TIMEOUT; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_write  in  1  CPU store strobe, sampled on the rising edge.
- data_memory_addr  in  32  CPU byte address.
- write_data  in  32  CPU store data.
- read_data  out  32  combinational read mux.
- hit  out  1  combinational; data_memory_addr matches one of the four decoded words.
- done  out  1  state != RUN.
- pass  out  1  state == PASS.
- fail  out  1  state == FAIL or TIMEOUT.
- status  out  2  encoded state.
- fail_addr  out  32  address of the offending store.
- fail_data  out  32  data of the offending store.
- cycle_count  out  32  cycles spent in RUN.
- store_count  out  16  accepted stores while in RUN.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state = RUN; scratch = result = fail_addr = fail_data = 0; cycle_count = store_count = 0; done = pass = fail = 0; status = 0.
- Reset asserted mid-run or in a terminal state returns the block to these values at the next edge.

FSM states: RUN, PASS, FAIL, TIMEOUT.

RUN, evaluated each rising edge in this priority order:
1. mem_write && data_memory_addr[1:0] != 0 (misaligned store):
   - -> FAIL; capture fail_addr and fail_data.
2. mem_write && data_memory_addr == RESULT_ADDR:
   - result <= write_data.
   - -> PASS if write_data == EXPECTED; otherwise -> FAIL with fail_addr/fail_data captured.
3. mem_write && data_memory_addr == SCRATCH_ADDR:
   - scratch <= write_data; stay in RUN.
4. mem_write to any other address:
   - -> FAIL (stray store); capture fail_addr and fail_data.
5. No store and cycle_count == TIMEOUT_CYCLES-1:
   - -> TIMEOUT.

RUN, counters:
- cycle_count increments every RUN cycle, including the transition cycle.
- store_count increments on every mem_write in RUN and saturates at 16'hFFFF.

Simultaneous events:
- A store on the timeout cycle is evaluated instead of the timeout: store wins.
- Reset overrides everything.

Terminal states (PASS, FAIL, TIMEOUT):
- Sticky until reset.
- Stores are ignored: no register or counter updates.
- Counters freeze.

Outputs:
- done, pass, fail and status are registered state decodes. They are valid the cycle after the deciding edge.

read_data (combinational, no latency):
- SCRATCH_ADDR -> scratch.
- RESULT_ADDR -> result.
- STATUS_ADDR -> {30'b0, status}.
- CYCLE_ADDR -> cycle_count.
- Any other address -> 0, with hit = 0.
- The read path never changes state.

Widths:
- Address compares are full 32-bit.
- cycle_count wraps are impossible because TIMEOUT_CYCLES < 2^32.

Decomposition:
- Package mmio_pkg:
  - typedef enum logic [1:0] status_e {ST_RUN=0, ST_PASS=1, ST_FAIL=2, ST_TIMEOUT=3}.
  - Default address constants MMIO_SCRATCH/RESULT/STATUS/CYCLE.
  - Constant MMIO_EXPECTED.
- Sub-module mmio_addr_decode: combinational decoder producing is_scratch, is_result, is_status, is_cycle and misaligned from data_memory_addr.
- The FSM, counters and read mux live in mmio_result_port.

Test Plan:
1. Store 3 to addr 96, then 7 to addr 100 -> scratch = 3, PASS one cycle later, pass = 1, status = 1, store_count = 2. A read of addr 100 returns 7.
2. Store 5 to addr 100 -> FAIL, fail_addr = 100, fail_data = 5, result = 5, fail = 1, status = 2.
3. Store 9 to addr 200, then 7 to addr 100 -> FAIL after the first store; fail_addr = 200. The second store is ignored: result = 0, store_count = 1.
4. Store to addr 97 -> FAIL (misaligned), fail_addr = 97.
5. TIMEOUT_CYCLES = 8, no stores -> TIMEOUT after the 8th RUN edge, cycle_count = 8, status = 3.
   - Rerun with a store of 7 to addr 100 on cycle 8 -> PASS, not TIMEOUT.
6. In PASS, assert reset for one cycle -> all outputs return to reset values, state = RUN. A new store of 7 to addr 100 -> PASS again.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and default address map for the MMIO result port.
// The status encoding is also the value software reads from the status word.
package mmio_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } status_e;

   localparam logic [ADDR_W-1:0] MMIO_SCRATCH  = 32'd96;
   localparam logic [ADDR_W-1:0] MMIO_RESULT   = 32'd100;
   localparam logic [ADDR_W-1:0] MMIO_STATUS   = 32'd104;
   localparam logic [ADDR_W-1:0] MMIO_CYCLE    = 32'd108;
   localparam logic [DATA_W-1:0] MMIO_EXPECTED = 32'd7;
   localparam int unsigned       MMIO_TIMEOUT  = 4096;

endpackage

// File: rtl/mmio_addr_decode.sv
// Full-width address decoder for the four MMIO words.
// It also flags stores that are not word-aligned.
module mmio_addr_decode
   import mmio_pkg::*;
#(
   parameter logic [ADDR_W-1:0] SCRATCH_ADDR = MMIO_SCRATCH,
   parameter logic [ADDR_W-1:0] RESULT_ADDR  = MMIO_RESULT,
   parameter logic [ADDR_W-1:0] STATUS_ADDR  = MMIO_STATUS,
   parameter logic [ADDR_W-1:0] CYCLE_ADDR   = MMIO_CYCLE
) (
   input  logic [ADDR_W-1:0] data_memory_addr,
   output logic              is_scratch,
   output logic              is_result,
   output logic              is_status,
   output logic              is_cycle,
   output logic              misaligned
);

   assign is_scratch = (data_memory_addr == SCRATCH_ADDR);
   assign is_result  = (data_memory_addr == RESULT_ADDR);
   assign is_status  = (data_memory_addr == STATUS_ADDR);
   assign is_cycle   = (data_memory_addr == CYCLE_ADDR);
   assign misaligned = (data_memory_addr[1:0] != 2'b00);

endmodule

// File: rtl/mmio_result_port.sv
// Memory-mapped run verdict: watches CPU stores, decides PASS/FAIL/TIMEOUT,
// and offers a zero-latency read-back of scratch, result, status and cycle count.
module mmio_result_port
   import mmio_pkg::*;
#(
   parameter logic [ADDR_W-1:0] SCRATCH_ADDR   = MMIO_SCRATCH,
   parameter logic [ADDR_W-1:0] RESULT_ADDR    = MMIO_RESULT,
   parameter logic [ADDR_W-1:0] STATUS_ADDR    = MMIO_STATUS,
   parameter logic [ADDR_W-1:0] CYCLE_ADDR     = MMIO_CYCLE,
   parameter logic [DATA_W-1:0] EXPECTED       = MMIO_EXPECTED,
   parameter int unsigned       TIMEOUT_CYCLES = MMIO_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] data_memory_addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              hit,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        status,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [31:0]       cycle_count,
   output logic [CNT_W-1:0]  store_count
);

   localparam logic [31:0] LAST_RUN_CYCLE = 32'(TIMEOUT_CYCLES - 1);

   logic is_scratch, is_result, is_status, is_cycle, misaligned;

   status_e           state_q, state_d;
   logic [DATA_W-1:0] scratch_q, scratch_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;
   logic [31:0]       cycle_count_q, cycle_count_d;
   logic [CNT_W-1:0]  store_count_q, store_count_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;

   mmio_addr_decode #(
      .SCRATCH_ADDR (SCRATCH_ADDR),
      .RESULT_ADDR  (RESULT_ADDR),
      .STATUS_ADDR  (STATUS_ADDR),
      .CYCLE_ADDR   (CYCLE_ADDR)
   ) u_decode (
      .data_memory_addr (data_memory_addr),
      .is_scratch       (is_scratch),
      .is_result        (is_result),
      .is_status        (is_status),
      .is_cycle         (is_cycle),
      .misaligned       (misaligned)
   );

   // Verdict FSM and counters; terminal states hold everything frozen.
   always_comb begin
      state_d       = state_q;
      scratch_d     = scratch_q;
      result_d      = result_q;
      fail_addr_d   = fail_addr_q;
      fail_data_d   = fail_data_q;
      cycle_count_d = cycle_count_q;
      store_count_d = store_count_q;

      if (state_q == ST_RUN) begin
         cycle_count_d = cycle_count_q + 32'd1;
         if (mem_write) begin
            if (store_count_q != {CNT_W{1'b1}}) begin
               store_count_d = store_count_q + CNT_W'(1);
            end
            if (misaligned) begin
               state_d     = ST_FAIL;
               fail_addr_d = data_memory_addr;
               fail_data_d = write_data;
            end else if (is_result) begin
               result_d = write_data;
               if (write_data == EXPECTED) begin
                  state_d = ST_PASS;
               end else begin
                  state_d     = ST_FAIL;
                  fail_addr_d = data_memory_addr;
                  fail_data_d = write_data;
               end
            end else if (is_scratch) begin
               scratch_d = write_data;
            end else begin
               state_d     = ST_FAIL;
               fail_addr_d = data_memory_addr;
               fail_data_d = write_data;
            end
         end else if (cycle_count_q == LAST_RUN_CYCLE) begin
            state_d = ST_TIMEOUT;
         end
      end

      done_d = (state_d != ST_RUN);
      pass_d = (state_d == ST_PASS);
      fail_d = (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RUN;
         scratch_q     <= '0;
         result_q      <= '0;
         fail_addr_q   <= '0;
         fail_data_q   <= '0;
         cycle_count_q <= '0;
         store_count_q <= '0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         scratch_q     <= scratch_d;
         result_q      <= result_d;
         fail_addr_q   <= fail_addr_d;
         fail_data_q   <= fail_data_d;
         cycle_count_q <= cycle_count_d;
         store_count_q <= store_count_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         fail_q        <= fail_d;
      end
   end

   // Read mux is purely combinational so a single-cycle load sees it in time.
   always_comb begin
      read_data = '0;
      if (is_scratch) begin
         read_data = scratch_q;
      end else if (is_result) begin
         read_data = result_q;
      end else if (is_status) begin
         read_data = {30'b0, state_q};
      end else if (is_cycle) begin
         read_data = cycle_count_q;
      end
   end

   assign hit         = is_scratch | is_result | is_status | is_cycle;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign status      = state_q;
   assign fail_addr   = fail_addr_q;
   assign fail_data   = fail_data_q;
   assign cycle_count = cycle_count_q;
   assign store_count = store_count_q;

endmodule

// File: tb/tb_mmio_result_port.sv
// Directed bench for mmio_result_port with an 8-cycle timeout.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mmio_result_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write;
   logic [31:0] data_memory_addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        hit;
   logic        done;
   logic        pass;
   logic        fail;
   logic [1:0]  status;
   logic [31:0] fail_addr;
   logic [31:0] fail_data;
   logic [31:0] cycle_count;
   logic [15:0] store_count;

   int checks = 0;
   int errors = 0;

   mmio_result_port #(.TIMEOUT_CYCLES(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .mem_write        (mem_write),
      .data_memory_addr (data_memory_addr),
      .write_data       (write_data),
      .read_data        (read_data),
      .hit              (hit),
      .done             (done),
      .pass             (pass),
      .fail             (fail),
      .status           (status),
      .fail_addr        (fail_addr),
      .fail_data        (fail_data),
      .cycle_count      (cycle_count),
      .store_count      (store_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      mem_write        = 1'b0;
      data_memory_addr = 32'd0;
      write_data       = 32'd0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_write        = 1'b1;
      data_memory_addr = a;
      write_data       = d;
      step();
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
      data_memory_addr = a;
      #1;
      check(tag, read_data, exp);
      check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
      data_memory_addr = 32'd0;
   endtask

   task automatic check_verdict(input string tag, input logic [1:0] st);
      check({tag, "_status"}, 32'(status), 32'(st));
      check({tag, "_done"}, 32'(done), 32'(st != 2'd0));
      check({tag, "_pass"}, 32'(pass), 32'(st == 2'd1));
      check({tag, "_fail"}, 32'(fail), 32'(st == 2'd2 || st == 2'd3));
   endtask

   initial begin
      idle();
      reset = 1'b0;

      // Reset state
      do_reset();
      check_verdict("rst", 2'd0);
      check("rst_fail_addr", fail_addr, 32'd0);
      check("rst_fail_data", fail_data, 32'd0);
      check("rst_cycles", cycle_count, 32'd0);
      check("rst_stores", 32'(store_count), 32'd0);
      rd("rst_rd_result", 32'd100, 32'd0, 1'b1);

      // Test 1: scratch then good result
      store(32'd96, 32'd3);
      check_verdict("t1_mid", 2'd0);
      rd("t1_rd_scratch", 32'd96, 32'd3, 1'b1);
      store(32'd100, 32'd7);
      check_verdict("t1", 2'd1);
      check("t1_stores", 32'(store_count), 32'd2);
      check("t1_cycles", cycle_count, 32'd2);
      rd("t1_rd_result", 32'd100, 32'd7, 1'b1);
      rd("t1_rd_status", 32'd104, 32'd1, 1'b1);
      rd("t1_rd_cycle", 32'd108, 32'd2, 1'b1);
      rd("t1_rd_other", 32'd112, 32'd0, 1'b0);
      step();
      check("t1_frozen_cycles", cycle_count, 32'd2);

      // Test 2: wrong result value
      do_reset();
      store(32'd100, 32'd5);
      check_verdict("t2", 2'd2);
      check("t2_fail_addr", fail_addr, 32'd100);
      check("t2_fail_data", fail_data, 32'd5);
      rd("t2_rd_result", 32'd100, 32'd5, 1'b1);

      // Test 3: stray store, then ignored result store
      do_reset();
      store(32'd200, 32'd9);
      check_verdict("t3", 2'd2);
      store(32'd100, 32'd7);
      check_verdict("t3_after", 2'd2);
      check("t3_fail_addr", fail_addr, 32'd200);
      check("t3_fail_data", fail_data, 32'd9);
      check("t3_stores", 32'(store_count), 32'd1);
      check("t3_cycles", cycle_count, 32'd1);
      rd("t3_rd_result", 32'd100, 32'd0, 1'b1);

      // Test 4: misaligned store
      do_reset();
      store(32'd97, 32'h55);
      check_verdict("t4", 2'd2);
      check("t4_fail_addr", fail_addr, 32'd97);
      check("t4_fail_data", fail_data, 32'h55);

      // Test 5a: timeout after the 8th RUN edge
      do_reset();
      for (int i = 0; i < 7; i++) step();
      check_verdict("t5_edge7", 2'd0);
      check("t5_cycles7", cycle_count, 32'd7);
      step();
      check_verdict("t5", 2'd3);
      check("t5_cycles", cycle_count, 32'd8);
      rd("t5_rd_status", 32'd104, 32'd3, 1'b1);
      step();
      check("t5_frozen", cycle_count, 32'd8);

      // Test 5b: store on the timeout cycle wins
      do_reset();
      for (int i = 0; i < 7; i++) step();
      store(32'd100, 32'd7);
      check_verdict("t5b", 2'd1);
      check("t5b_cycles", cycle_count, 32'd8);

      // Test 6: reset out of PASS, then pass again
      do_reset();
      store(32'd96, 32'd11);
      store(32'd100, 32'd7);
      check_verdict("t6_pre", 2'd1);
      do_reset();
      check_verdict("t6_rst", 2'd0);
      check("t6_cycles", cycle_count, 32'd0);
      check("t6_stores", 32'(store_count), 32'd0);
      rd("t6_rd_scratch", 32'd96, 32'd0, 1'b1);
      rd("t6_rd_result", 32'd100, 32'd0, 1'b1);
      store(32'd100, 32'd7);
      check_verdict("t6_again", 2'd1);
      check("t6_stores_again", 32'(store_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
